// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-low {a,b,c,d,e,f,g} = seg[6:0].
package seg_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry n holds the pattern for hex digit n; entry F is listed first (MSB).
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

endpackage

// File: rtl/seg_scan_driver_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
module hex_seg_decoder
    import seg_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with dead-time blanking between digits.
// Optional decimal-point support is enabled by defining SEG_SCAN_DP_EN.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
`ifdef SEG_SCAN_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp,
`endif
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    frame_start
);

    localparam int SLOT_MAX  = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_RANGE = (SLOT_MAX > 2) ? SLOT_MAX : 2;
    localparam int CW        = $clog2(CNT_RANGE);
    localparam int IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] DRIVE_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST  = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_DIGITS - 1);
    localparam state_t        START_STATE = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_display;
`ifdef SEG_SCAN_DP_EN
    logic [NUM_DIGITS-1:0]   r_dp_shadow;
    logic [NUM_DIGITS-1:0]   r_dp_display;
    logic [NUM_DIGITS-1:0]   w_dp_src;
`endif

    logic                    w_boundary;
    logic [4*NUM_DIGITS-1:0] w_nibble_src;
    logic [3:0]              w_nibble;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_an_drive;

    assign w_boundary = (r_state == START_STATE) && (r_cnt == '0) && (r_idx == '0);

    // Without blanking the boundary cycle is already a DRIVE cycle, so it reads the
    // value being promoted to the display register to keep the whole frame consistent.
    assign w_nibble_src = w_boundary ? r_shadow : r_display;
    assign w_nibble     = w_nibble_src[4*r_idx +: 4];
`ifdef SEG_SCAN_DP_EN
    assign w_dp_src     = w_boundary ? r_dp_shadow : r_dp_display;
`endif

    always_comb begin
        w_an_drive        = '1;
        w_an_drive[r_idx] = ~digit_en[r_idx];
    end

    hex_seg_decoder u_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    // Scan FSM; outputs are registered from the current state so they trail it by one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= START_STATE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_display   <= '0;
            an          <= '1;
            seg         <= SEG_OFF;
            frame_start <= 1'b0;
`ifdef SEG_SCAN_DP_EN
            r_dp_shadow  <= '0;
            r_dp_display <= '0;
            dp           <= 1'b1;
`endif
        end else begin
            if (load) begin
                r_shadow <= data;
`ifdef SEG_SCAN_DP_EN
                r_dp_shadow <= dp_in;
`endif
            end
            if (w_boundary) begin
                r_display <= r_shadow;
`ifdef SEG_SCAN_DP_EN
                r_dp_display <= r_dp_shadow;
`endif
            end
            frame_start <= w_boundary;

            case (r_state)
                BLANK: begin
                    an  <= '1;
                    seg <= SEG_OFF;
`ifdef SEG_SCAN_DP_EN
                    dp  <= 1'b1;
`endif
                    if (r_cnt == BLANK_LAST) begin
                        r_state <= DRIVE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    an  <= w_an_drive;
                    seg <= w_seg;
`ifdef SEG_SCAN_DP_EN
                    dp  <= ~(digit_en[r_idx] & w_dp_src[r_idx]);
`endif
                    if (r_cnt == DRIVE_LAST) begin
                        r_state <= START_STATE;
                        r_cnt   <= '0;
                        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= START_STATE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: a 4-digit driver with blanking and a 1-digit driver without
// blanking run side by side against a frame-position reference model.
`timescale 1ns/1ps
module tb_seg_scan_driver;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = BC + RD;
    localparam int FRAME = ND * SLOT;
    localparam int FRAMEB = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
        logic       dp;
        logic       anB;
        logic [6:0] segB;
        logic       fsB;
        logic       dpB;
    } expect_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN;
    logic        load;
    logic [15:0] data;
    logic [3:0]  digitEn;
    logic [3:0]  dpIn;

    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frameStart;
    logic        anB;
    logic [6:0]  segB;
    logic        frameStartB;
`ifdef SEG_SCAN_DP_EN
    logic        dp;
    logic        dpB;
    logic [3:0]  dpShA, dpDispA;
    logic        dpShB, dpDispB;
`endif

    expect_t     expQ[$];
    int          errors = 0;
    int          checks = 0;
    int          posA = 0;
    int          posB = 0;
    logic [15:0] shadowA, dispA;
    logic [3:0]  shadowB, dispB;

    seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dutA (
        .clk         (clk),
        .reset       (rstN),
        .load        (load),
        .data        (data),
        .digit_en    (digitEn),
`ifdef SEG_SCAN_DP_EN
        .dp_in       (dpIn),
        .dp          (dp),
`endif
        .an          (an),
        .seg         (seg),
        .frame_start (frameStart)
    );

    seg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(4), .BLANK_CYCLES(0)) dutB (
        .clk         (clk),
        .reset       (rstN),
        .load        (load),
        .data        (data[3:0]),
        .digit_en    (digitEn[0:0]),
`ifdef SEG_SCAN_DP_EN
        .dp_in       (dpIn[0:0]),
        .dp          (dpB),
`endif
        .an          (anB),
        .seg         (segB),
        .frame_start (frameStartB)
    );

    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
            4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model one clock edge from the current inputs, queue the expectation, then compare.
    task automatic applyStimulus(input int cycles);
        expect_t    e;
        expect_t    o;
        int         off;
        int         d;
        logic [3:0] expAn;
        for (int i = 0; i < cycles; i++) begin
            e = '0;
            if (!rstN) begin
                posA = 0;  posB = 0;
                shadowA = '0;  dispA = '0;  shadowB = '0;  dispB = '0;
`ifdef SEG_SCAN_DP_EN
                dpShA = '0;  dpDispA = '0;  dpShB = 1'b0;  dpDispB = 1'b0;
`endif
                e.an = 4'hF;  e.seg = 7'h7F;  e.fs = 1'b0;  e.dp = 1'b1;
                e.anB = 1'b1; e.segB = 7'h7F; e.fsB = 1'b0; e.dpB = 1'b1;
            end else begin
                if (posA == 0) begin
                    dispA = shadowA;
`ifdef SEG_SCAN_DP_EN
                    dpDispA = dpShA;
`endif
                end
                if (load) begin
                    shadowA = data;
`ifdef SEG_SCAN_DP_EN
                    dpShA = dpIn;
`endif
                end
                off  = posA % SLOT;
                d    = posA / SLOT;
                e.fs = (posA == 0);
                e.dp = 1'b1;
                if (off < BC) begin
                    e.an  = 4'hF;
                    e.seg = 7'h7F;
                end else begin
                    expAn    = 4'hF;
                    expAn[d] = ~digitEn[d];
                    e.an     = expAn;
                    e.seg    = hexSeg(dispA[4*d +: 4]);
`ifdef SEG_SCAN_DP_EN
                    e.dp     = digitEn[d] ? ~dpDispA[d] : 1'b1;
`endif
                end
                posA = (posA + 1) % FRAME;

                if (posB == 0) begin
                    dispB = shadowB;
`ifdef SEG_SCAN_DP_EN
                    dpDispB = dpShB;
`endif
                end
                if (load) begin
                    shadowB = data[3:0];
`ifdef SEG_SCAN_DP_EN
                    dpShB = dpIn[0];
`endif
                end
                e.anB  = ~digitEn[0];
                e.segB = hexSeg(dispB);
                e.fsB  = (posB == 0);
                e.dpB  = 1'b1;
`ifdef SEG_SCAN_DP_EN
                e.dpB  = digitEn[0] ? ~dpDispB : 1'b1;
`endif
                posB = (posB + 1) % FRAMEB;
            end
            expQ.push_back(e);
            @(posedge clk);
            #1;
            o = expQ.pop_front();
            checkOutput("an",           {12'd0, an},         {12'd0, o.an});
            checkOutput("seg",          {9'd0, seg},         {9'd0, o.seg});
            checkOutput("frame_start",  {15'd0, frameStart}, {15'd0, o.fs});
            checkOutput("anB",          {15'd0, anB},        {15'd0, o.anB});
            checkOutput("segB",         {9'd0, segB},        {9'd0, o.segB});
            checkOutput("frame_startB", {15'd0, frameStartB},{15'd0, o.fsB});
`ifdef SEG_SCAN_DP_EN
            checkOutput("dp",           {15'd0, dp},         {15'd0, o.dp});
            checkOutput("dpB",          {15'd0, dpB},        {15'd0, o.dpB});
`endif
        end
    endtask

    initial begin
        rstN    = 1'b0;
        load    = 1'b0;
        data    = 16'h0000;
        digitEn = 4'hF;
        dpIn    = 4'b0010;
        applyStimulus(3);

        rstN = 1'b1;
        load = 1'b1;
        applyStimulus(1);
        load = 1'b0;
        applyStimulus(24);

        data = 16'h1234;
        load = 1'b1;
        applyStimulus(1);
        load = 1'b0;
        applyStimulus(47);

        for (int k = 0; k < FRAME && posA != 14; k++) applyStimulus(1);
        data = 16'hABCD;
        load = 1'b1;
        applyStimulus(1);
        load = 1'b0;
        applyStimulus(48);

        digitEn = 4'b0101;
        applyStimulus(48);
        digitEn = 4'hF;

        repeat (6) begin
            data = 16'($urandom);
            dpIn = 4'($urandom);
            load = 1'b1;
            applyStimulus(1);
            load = 1'b0;
            applyStimulus($urandom_range(3, 20));
            digitEn = 4'($urandom);
        end
        digitEn = 4'hF;
        applyStimulus(30);

        for (int k = 0; k < FRAME && posA != 9; k++) applyStimulus(1);
        rstN = 1'b0;
        applyStimulus(1);
        rstN = 1'b1;
        applyStimulus(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
